// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths, block type and assembly-state enum for the AES block packer
package aes_pkg;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {W0, W1, W2, W3} asm_state_t;
endpackage

// File: rtl/aes_block_fifo.sv
// rtl/aes_block_fifo.sv - synchronous FIFO of completed 128-bit blocks with push/pop/count
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  block_t     push_data,
  input  logic       pop,
  output block_t     head,
  output logic [2:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  block_t          mem [2**PW];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            loaded;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop frees the head slot in the same edge, so a full FIFO can take a push alongside it.
  assign do_pop  = pop && (count != 3'd0);
  assign do_push = push && ((count != 3'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 3'd0;
      loaded <= 1'b0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 3'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
        loaded <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Storage is not reset; the head reads zero until the first block has been written.
  assign head = loaded ? mem[rd_ptr] : '0;
endmodule

// File: rtl/aes_block_packer.sv
// rtl/aes_block_packer.sv - packs 32-bit upstream words big-endian into 128-bit AES blocks
module aes_block_packer #(
  parameter int NUM_BLOCKS      = 2,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic         hclk,
  input  logic         hrst,
  input  logic         word_valid,
  input  logic [31:0]  word_data,
  output logic         word_ready,
  input  logic         clear,
  output logic         blk_valid,
  output logic [127:0] blk_data,
  input  logic         blk_ready,
  output logic         partial,
  output logic [2:0]   blk_count
);
  import aes_pkg::*;

  localparam asm_state_t LAST = asm_state_t'(2'(WORDS_PER_BLOCK - 1));

  asm_state_t                  state;
  asm_state_t                  state_next;
  logic [BLOCK_W-WORD_W-1:0]   asm_q;
  logic                        word_accept;
  logic                        blk_push;
  logic                        buf_full;
  block_t                      push_block;

  assign buf_full    = (blk_count == 3'(NUM_BLOCKS));
  assign word_accept = word_valid && word_ready;
  assign blk_push    = word_accept && (state == LAST);
  // The final word completes the block directly, so the assembly register is free next cycle.
  assign push_block  = {asm_q, word_data};
  assign blk_valid   = (blk_count != 3'd0);

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state <= W0;
    end else if (clear) begin
      state <= W0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (word_accept) begin
      case (state)
        W0: state_next = W1;
        W1: state_next = W2;
        W2: state_next = W3;
        W3: state_next = W0;
      endcase
    end
  end

  // word_ready depends only on registered state, never on blk_ready.
  always_comb begin
    word_ready = 1'b1;
    partial    = 1'b0;
    if ((state == LAST) && buf_full) begin
      word_ready = 1'b0;
    end
    if (state != W0) begin
      partial = 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      asm_q <= '0;
    end else if (word_accept && !clear) begin
      asm_q <= {asm_q[BLOCK_W-2*WORD_W-1:0], word_data};
    end
  end

  aes_block_fifo #(
    .DEPTH(NUM_BLOCKS)
  ) u_fifo (
    .clk      (hclk),
    .rst      (hrst),
    .clear    (clear),
    .push     (blk_push),
    .push_data(push_block),
    .pop      (blk_ready),
    .head     (blk_data),
    .count    (blk_count)
  );
endmodule

// File: doc/aes_block_packer.md
AES_BLOCK_PACKER -- requirements
Module: aes_block_packer

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 2, meaning the depth of the completed-block buffer in 128-bit blocks (legal values 1..4).
REQ-002 SHALL have parameter WORDS_PER_BLOCK, default 4, meaning the number of 32-bit words per AES block (fixed at 4; other values illegal).
REQ-003 hclk  in  1  single clock; all state updates on the rising edge.
REQ-004 hrst  in  1  reset, synchronous, active-high.
REQ-005 word_valid  in  1  upstream word present (AHB master read data).
REQ-006 word_data  in  32  upstream word.
REQ-007 word_ready  out  1  packer can accept word_data this cycle.
REQ-008 clear  in  1  synchronous flush of all held data.
REQ-009 blk_valid  out  1  head block present for the AES core.
REQ-010 blk_data  out  128  head block.
REQ-011 blk_ready  in  1  AES core accepts the head block.
REQ-012 partial  out  1  assembly register holds 1..3 words.
REQ-013 blk_count  out  3  completed blocks buffered, 0..NUM_BLOCKS.

Function
REQ-014 A word SHALL be accepted only in a cycle with word_valid=1 and word_ready=1; a block SHALL be popped only in a cycle with blk_valid=1 and blk_ready=1.
REQ-015 Assembly SHALL be a 4-state FSM W0->W1->W2->W3->W0, advancing one state per accepted word and holding otherwise.
REQ-016 Word ordering SHALL be big-endian: the word accepted in W0 goes to bits [127:96], W1 to [95:64], W2 to [63:32], W3 to [31:0].
REQ-017 A word accepted in W3 SHALL push the completed 128-bit block into the buffer in the same edge; the assembly register SHALL be free for a new W0 word in the next cycle.
REQ-018 word_ready SHALL be 0 only when the state is W3 and blk_count=NUM_BLOCKS; there SHALL be no combinational path from blk_ready to word_ready.
REQ-019 Words in W0..W2 SHALL be accepted even when the buffer is full.
REQ-020 Latency: when the buffer is empty, a 4th word accepted at edge N SHALL make blk_valid=1 with that block on blk_data in the cycle after edge N.
REQ-021 The buffer SHALL be FIFO ordered; blk_valid SHALL equal (blk_count!=0); blk_data SHALL hold stable while blk_valid=1 and blk_ready=0.
REQ-022 A simultaneous push and pop SHALL leave blk_count unchanged and preserve ordering, including when blk_count=1 (the new block becomes head the next cycle).
REQ-023 blk_ready while blk_valid=0 SHALL be ignored.
REQ-024 partial SHALL be 1 exactly when the state is W1, W2 or W3.
REQ-025 clear=1 SHALL, at the next edge, set the state to W0, set blk_count to 0 and discard any word or pop presented in the same cycle (clear wins).

Reset
REQ-026 hrst=1 SHALL, at the next edge, set the state to W0, blk_count=0, blk_valid=0, partial=0 and word_ready=1; hrst SHALL take priority over clear and all handshakes, including mid-block.
REQ-027 blk_data SHALL read 128'h0 after reset until the first push; reset of the buffer storage array is otherwise not required.

Structure
REQ-028 Shared package aes_pkg SHALL hold WORD_W=32, BLOCK_W=128, WORDS_PER_BLOCK=4, typedef block_t (logic [127:0]) and the assembly-state enum {W0,W1,W2,W3}.
REQ-029 The completed-block buffer SHALL be a sub-module aes_block_fifo (synchronous FIFO of block_t, depth NUM_BLOCKS, with push/pop/count); the FSM and word shifting SHALL live in aes_block_packer.

Verification
REQ-030 Stream with blk_ready=1: words 00112233, 44556677, 8899AABB, CCDDEEFF accepted back-to-back -> one cycle after the 4th word, blk_data=00112233_44556677_8899AABB_CCDDEEFF, blk_valid=1 for one cycle.
REQ-031 Backpressure with blk_ready=0 and 12 words offered continuously, NUM_BLOCKS=2 -> blk_count reaches 2, the state sits in W3 with word_ready=0, and the 12th word is held; after a pop, word_ready=1, that word is accepted and blocks emerge in order.
REQ-032 Simultaneous push and pop at blk_count=1 -> blk_count stays 1, the next head equals the just-completed block, and no block is lost or duplicated.
REQ-033 Two words accepted (partial=1), then clear=1 with word_valid=1 -> state W0, partial=0, blk_count=0, and the offered word is discarded; the next 4 words form a clean block.
REQ-034 hrst=1 asserted in W2 with blk_count=2 -> next cycle blk_valid=0, blk_count=0, partial=0, word_ready=1, blk_data=0.
REQ-035 Random valid/ready toggling over 1000 words compared against a reference queue -> output blocks match in value and order, and blk_data is stable on every stalled cycle.
